// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access widths, direction, FSM states.
// Byte count helper used by both the error check and the lane aligner.
package mem_pkg;

  localparam logic [1:0] MEM_WIDTH_B = 2'b00;
  localparam logic [1:0] MEM_WIDTH_H = 2'b01;
  localparam logic [1:0] MEM_WIDTH_W = 2'b10;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_WR_B = 2'd3
  } state_t;

  // The reserved width 2'b11 maps to 4 bytes; it is rejected separately.
  function automatic logic [2:0] mem_nbytes(input logic [1:0] width);
    case (width)
      MEM_WIDTH_B: mem_nbytes = 3'd1;
      MEM_WIDTH_H: mem_nbytes = 3'd2;
      default:     mem_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational little-endian lane mapping for a 1/2/4-byte access at any byte offset.
// Produces word A/B byte enables and write data, the split flag and the extended load value.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_a,
  input  logic [31:0] i_rdata_b,
  output logic        o_split,
  output logic [3:0]  o_be_a,
  output logic [3:0]  o_be_b,
  output logic [31:0] o_wdata_a,
  output logic [31:0] o_wdata_b,
  output logic [31:0] o_load
);

  logic [3:0]  w_span;
  logic [3:0]  w_mask;
  logic [7:0]  w_be_all;
  logic [31:0] w_wmask;
  logic [63:0] w_wd;
  logic [31:0] w_raw;

  always_comb begin
    w_span  = {2'b00, i_offset} + {1'b0, mem_nbytes(i_width)};
    o_split = (w_span > 4'd4);

    case (i_width)
      MEM_WIDTH_B: w_mask = 4'b0001;
      MEM_WIDTH_H: w_mask = 4'b0011;
      default:     w_mask = 4'b1111;
    endcase

    // Treat words A and B as one 8-byte window starting at word A's lane 0.
    w_be_all = {4'b0000, w_mask} << i_offset;
    o_be_a   = w_be_all[3:0];
    o_be_b   = w_be_all[7:4];

    w_wmask   = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    w_wd      = {32'h0, i_wdata & w_wmask} << {i_offset, 3'b000};
    o_wdata_a = w_wd[31:0];
    o_wdata_b = w_wd[63:32];

    w_raw = 32'({i_rdata_b, i_rdata_a} >> {i_offset, 3'b000});
    case (i_width)
      MEM_WIDTH_B: o_load = i_signed ? {{24{w_raw[7]}}, w_raw[7:0]}   : {24'h0, w_raw[7:0]};
      MEM_WIDTH_H: o_load = i_signed ? {{16{w_raw[15]}}, w_raw[15:0]} : {16'h0, w_raw[15:0]};
      default:     o_load = w_raw;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder onto a word-wide 1-cycle SRAM; splits word-crossing accesses in two.
// Latency: error/write 1, split write 2, read 2, split read 3; req_ready only in IDLE, responses never stall.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_ADDR_W = 14
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic                   req_rw,
  input  logic [1:0]             req_width,
  input  logic                   req_signed,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   sram_en,
  output logic [3:0]             sram_we,
  output logic [WORD_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata
);

  localparam int BA_W = WORD_ADDR_W + 2;
  localparam int LW   = BA_W + 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_off;
  logic [1:0]             r_width;
  logic                   r_signed;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata_a;
  logic [WORD_ADDR_W-1:0] r_word_b;

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_err;
  logic [LW-1:0]          w_last;
  logic [WORD_ADDR_W-1:0] w_word_a;
  logic [1:0]             w_la_off;
  logic [1:0]             w_la_width;
  logic                   w_la_signed;
  logic [31:0]            w_la_wdata;
  logic [31:0]            w_la_rdata_a;
  logic                   w_la_split;
  logic [3:0]             w_be_a;
  logic [3:0]             w_be_b;
  logic [31:0]            w_wd_a;
  logic [31:0]            w_wd_b;
  logic [31:0]            w_la_load;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_word_a  = req_addr[BA_W-1:2];

  // Carry out of the last-byte address means the access runs past the top; no wrap.
  assign w_last = {1'b0, req_addr[BA_W-1:0]} + LW'(mem_nbytes(req_width)) - LW'(1);
  assign w_err  = (req_width == 2'b11) || (req_addr[31:BA_W] != '0) || w_last[BA_W];

  // In IDLE the aligner sees the live request; afterwards the captured copy.
  assign w_la_off     = w_idle ? req_addr[1:0] : r_off;
  assign w_la_width   = w_idle ? req_width     : r_width;
  assign w_la_signed  = w_idle ? req_signed    : r_signed;
  assign w_la_wdata   = w_idle ? req_wdata     : r_wdata;
  assign w_la_rdata_a = (r_state == ST_RD_B) ? r_rdata_a : sram_rdata;

  lane_align u_lane_align (
    .i_offset  (w_la_off),
    .i_width   (w_la_width),
    .i_signed  (w_la_signed),
    .i_wdata   (w_la_wdata),
    .i_rdata_a (w_la_rdata_a),
    .i_rdata_b (sram_rdata),
    .o_split   (w_la_split),
    .o_be_a    (w_be_a),
    .o_be_b    (w_be_b),
    .o_wdata_a (w_wd_a),
    .o_wdata_b (w_wd_b),
    .o_load    (w_la_load)
  );

  always_comb begin
    w_state_nxt = r_state;
    sram_en     = 1'b0;
    sram_we     = 4'b0000;
    sram_addr   = '0;
    sram_wdata  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_err) begin
          sram_en   = 1'b1;
          sram_addr = w_word_a;
          if (req_rw == MEM_WRITE) begin
            sram_we    = w_be_a;
            sram_wdata = w_wd_a;
            if (w_la_split) w_state_nxt = ST_WR_B;
          end else begin
            w_state_nxt = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        if (w_la_split) begin
          sram_en     = 1'b1;
          sram_addr   = r_word_b;
          w_state_nxt = ST_RD_B;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_B: w_state_nxt = ST_IDLE;
      ST_WR_B: begin
        sram_en     = 1'b1;
        sram_we     = w_be_b;
        sram_addr   = r_word_b;
        sram_wdata  = w_wd_b;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Keep the SRAM quiet for the whole reset pulse, not just after the state clears.
    if (rst) begin
      sram_en    = 1'b0;
      sram_we    = 4'b0000;
      sram_addr  = '0;
      sram_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_off      <= 2'b00;
      r_width    <= 2'b00;
      r_signed   <= 1'b0;
      r_wdata    <= 32'h0;
      r_rdata_a  <= 32'h0;
      r_word_b   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_off    <= req_addr[1:0];
            r_width  <= req_width;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            r_word_b <= w_word_a + WORD_ADDR_W'(1);
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_rw == MEM_WRITE && !w_la_split) begin
              resp_valid <= 1'b1;
            end
          end
        end
        ST_RD_A: begin
          if (w_la_split) begin
            r_rdata_a <= sram_rdata;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= w_la_load;
          end
        end
        ST_RD_B: begin
          resp_valid <= 1'b1;
          resp_rdata <= w_la_load;
        end
        ST_WR_B: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference memory model plus directed literal checks.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int WAW = 14;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, req_rw, req_signed;
  logic [31:0]    req_addr, req_wdata;
  logic [1:0]     req_width;
  logic           resp_valid, resp_err;
  logic [31:0]    resp_rdata;
  logic           sram_en;
  logic [3:0]     sram_we;
  logic [WAW-1:0] sram_addr;
  logic [31:0]    sram_wdata, sram_rdata;

  data_mem_responder #(.WORD_ADDR_W(WAW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .req_width(req_width), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SRAM model; preload port lets the bench seed words without a second driver.
  logic [31:0]    sram_mem [0:16383];
  logic [31:0]    sram_rd_q;
  logic           pl_en = 1'b0;
  logic [WAW-1:0] pl_addr;
  logic [31:0]    pl_data;
  assign sram_rdata = sram_rd_q;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (sram_en) begin
      for (int i = 0; i < 4; i++)
        if (sram_we[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      if (sram_we == 4'b0000) sram_rd_q <= sram_mem[sram_addr];
    end
  end

  logic [7:0] ref_b [0:65535];

  typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
  typedef struct { int c; logic [WAW-1:0] addr; logic [3:0] we; logic [31:0] wdata; } log_t;
  exp_t exp_q[$];
  log_t slog[$];
  int          last_cyc;
  logic [31:0] last_rdata;
  logic        last_err;
  logic        run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (run_cmp && !rst) begin
      if (sram_en) slog.push_back('{cyc, sram_addr, sram_we, sram_wdata});
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q[0];
        exp_q.delete(0);
        check("resp_valid", {31'b0, resp_valid}, 32'd1);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        last_cyc   = cyc;
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end else if (resp_valid) begin
        check("resp_valid_unexpected", {31'b0, resp_valid}, 32'd0);
      end
    end
  end

  task automatic set_word(input int idx, input logic [31:0] v);
    pl_addr = WAW'(idx);
    pl_data = v;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_b[4*idx + k] = v[8*k +: 8];
  endtask

  // Reference: expected response computed from byte memory, then request driven.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rw,
                       input logic [1:0] w, input logic s, output int t);
    int   n;
    int   nb;
    int   lat;
    logic split;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      t = cyc;
      return;
    end
    nb      = (w == MEM_WIDTH_B) ? 1 : (w == MEM_WIDTH_H) ? 2 : 4;
    split   = (int'(a[1:0]) + nb) > 4;
    e.err   = (w == 2'b11) || (a[31:16] != 16'h0) || (longint'(a) + nb - 1 > 65535);
    e.rdata = 32'h0;
    if (e.err) lat = 1;
    else if (rw == MEM_WRITE) begin
      for (int k = 0; k < nb; k++) ref_b[int'(a[15:0]) + k] = wd[8*k +: 8];
      lat = split ? 2 : 1;
    end else begin
      for (int k = 0; k < nb; k++) e.rdata = e.rdata | (32'(ref_b[int'(a[15:0]) + k]) << (8*k));
      if (s && nb < 4 && e.rdata[8*nb-1]) e.rdata = e.rdata | (32'hFFFF_FFFF << (8*nb));
      lat = split ? 3 : 2;
    end
    e.due = cyc + lat;
    exp_q.push_back(e);
    req_addr = a; req_wdata = wd; req_rw = rw; req_width = w; req_signed = s;
    req_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [31:0] v_addr [21] = '{32'h100, 32'h100, 32'h101, 32'h103, 32'h105, 32'h106, 32'h105,
                               32'h10A, 32'h108, 32'h10C, 32'h10B, 32'hFFFF, 32'hFFFF, 32'hFFFF,
                               32'hFFFF, 32'hFFFC, 32'h10000, 32'h104, 32'h106, 32'h10E, 32'h10D};
  logic [31:0] v_wd   [21] = '{32'hA1B2C3D4, 0, 0, 0, 32'h7F, 32'h1234, 0, 32'hCAFEF00D, 0, 0, 0,
                               0, 32'h99, 0, 0, 0, 32'h1, 0, 0, 32'hFFEE, 0};
  logic        v_rw   [21] = '{0, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1};
  logic [1:0]  v_w    [21] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                               2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2};
  logic        v_s    [21] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1};

  logic [31:0] e_addr [3] = '{32'h40, 32'h0001_0000, 32'hFFFE};
  logic [1:0]  e_w    [3] = '{2'b11, MEM_WIDTH_W, MEM_WIDTH_W};

  initial begin
    int t;
    int t2;
    rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_wdata = 0;
    req_rw = MEM_READ; req_width = MEM_WIDTH_B; req_signed = 1'b0;
    for (int i = 0; i < 65536; i++) ref_b[i] = 8'h00;
    repeat (2) @(posedge clk); #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_err", {31'b0, resp_err}, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_sram_en", {31'b0, sram_en}, 0);
    check("rst_sram_we", {28'b0, sram_we}, 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_sram_wdata", sram_wdata, 0);
    rst = 1'b0; #1;
    check("ready_after_rst", {31'b0, req_ready}, 1);
    run_cmp = 1'b1;

    set_word(32'h10, 32'hDEADBEEF);
    for (int i = 32'h40; i <= 32'h44; i++) set_word(i, 32'h0);
    set_word(32'h3FFF, 32'h0);
    set_word(0, 32'h0080_0000);

    // Aligned LW
    slog.delete();
    issue(32'h40, 0, MEM_READ, MEM_WIDTH_W, 1'b0, t); wait_done();
    check("lw_rdata", last_rdata, 32'hDEADBEEF);
    check("lw_latency", last_cyc - t, 2);
    check("lw_nacc", slog.size(), 1);
    check("lw_acc_cyc", slog[0].c - t, 0);
    check("lw_acc_addr", 32'(slog[0].addr), 32'h10);
    check("lw_acc_we", {28'b0, slog[0].we}, 0);

    // LB vs LBU
    issue(32'h2, 0, MEM_READ, MEM_WIDTH_B, 1'b1, t); wait_done();
    check("lb_signed", last_rdata, 32'hFFFFFF80);
    issue(32'h2, 0, MEM_READ, MEM_WIDTH_B, 1'b0, t); wait_done();
    check("lbu", last_rdata, 32'h00000080);

    // Split LW
    set_word(0, 32'h44332211);
    set_word(1, 32'h88776655);
    slog.delete();
    issue(32'h3, 0, MEM_READ, MEM_WIDTH_W, 1'b0, t); wait_done();
    check("split_lw_rdata", last_rdata, 32'h77665544);
    check("split_lw_latency", last_cyc - t, 3);
    check("split_lw_nacc", slog.size(), 2);
    check("split_lw_a", 32'(slog[0].addr), 0);
    check("split_lw_b", 32'(slog[1].addr), 1);
    check("split_lw_b_cyc", slog[1].c - t, 1);

    // Split SH
    slog.delete();
    issue(32'h7, 32'h0000BEEF, MEM_WRITE, MEM_WIDTH_H, 1'b0, t); wait_done();
    check("split_sh_latency", last_cyc - t, 2);
    check("split_sh_nacc", slog.size(), 2);
    check("split_sh_a_cyc", slog[0].c - t, 0);
    check("split_sh_a_addr", 32'(slog[0].addr), 1);
    check("split_sh_a_we", {28'b0, slog[0].we}, 32'h8);
    check("split_sh_a_data", {24'b0, slog[0].wdata[31:24]}, 32'hEF);
    check("split_sh_b_cyc", slog[1].c - t, 1);
    check("split_sh_b_addr", 32'(slog[1].addr), 2);
    check("split_sh_b_we", {28'b0, slog[1].we}, 32'h1);
    check("split_sh_b_data", {24'b0, slog[1].wdata[7:0]}, 32'hBE);
    issue(32'h7, 0, MEM_READ, MEM_WIDTH_H, 1'b0, t); wait_done();
    check("split_lhu_back", last_rdata, 32'h0000BEEF);

    // Rejected accesses: no SRAM activity, error at T+1
    for (int i = 0; i < 3; i++) begin
      slog.delete();
      issue(e_addr[i], 0, MEM_READ, e_w[i], 1'b0, t); wait_done();
      check("err_flag", {31'b0, last_err}, 1);
      check("err_latency", last_cyc - t, 1);
      check("err_rdata", last_rdata, 0);
      check("err_no_sram", slog.size(), 0);
    end

    // Request accepted in the same cycle an error response is out
    issue(32'h0001_0000, 0, MEM_READ, MEM_WIDTH_B, 1'b0, t);
    issue(32'h40, 0, MEM_READ, MEM_WIDTH_W, 1'b0, t2);
    wait_done();
    check("b2b_accept_cyc", t2 - t, 1);
    check("b2b_rdata", last_rdata, 32'hDEADBEEF);

    // Mixed vectors, back to back, checked against the byte model
    for (int i = 0; i < 21; i++) issue(v_addr[i], v_wd[i], v_rw[i], v_w[i], v_s[i], t);
    wait_done();

    // Reset during a split read
    issue(32'h3, 0, MEM_READ, MEM_WIDTH_W, 1'b0, t);
    rst = 1'b1; #1;
    check("mid_rst_sram_en", {31'b0, sram_en}, 0);
    check("mid_rst_sram_addr", 32'(sram_addr), 0);
    check("mid_rst_sram_we", {28'b0, sram_we}, 0);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(32'h40, 0, MEM_READ, MEM_WIDTH_W, 1'b0, t); wait_done();
    check("post_rst_rdata", last_rdata, 32'hDEADBEEF);
    check("post_rst_latency", last_cyc - t, 2);

    // Stored words against the byte model
    for (int w = 0; w < 4; w++) check("mem_lo", sram_mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
    for (int w = 32'h40; w <= 32'h44; w++) check("mem_mid", sram_mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
    check("mem_top", sram_mem[16383], {ref_b[65535], ref_b[65534], ref_b[65533], ref_b[65532]});
    check("mem_top_lit", sram_mem[16383], 32'h9900_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the execute stage's load/store request interface (rw, width, signed-read).
Turns byte, halfword and word requests at any byte address into accesses on a 32-bit word-wide synchronous SRAM with byte enables and 1-cycle read latency.
Splits word-crossing (misaligned) accesses into two word accesses.
Returns sign- or zero-extended load data and a completion pulse.

Parameters:
WORD_ADDR_W, 14, SRAM word-address width; the byte space is 2^(WORD_ADDR_W+2) bytes (64 KiB by default).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_rw  in  1  1 = read, 0 = write (MEM_READ / MEM_WRITE)
req_width  in  2  MEM_WIDTH_B / MEM_WIDTH_H / MEM_WIDTH_W
req_signed  in  1  sign-extend load data; ignored for writes and for word reads
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for writes and errors
resp_err  out  1  valid with resp_valid; access rejected
sram_en  out  1  SRAM access strobe
sram_we  out  4  byte write enables, lane i = bits [8i+7:8i]; 0 for reads
sram_addr  out  WORD_ADDR_W  word address
sram_wdata  out  32  lane-aligned write data
sram_rdata  in  32  read data, valid the cycle after sram_en with sram_we=0

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. resp_valid=0, resp_err=0, resp_rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0. req_ready=1 after reset deasserts.
- Reset during a split write leaves word A written and word B unwritten; this is acceptable.
- Handshake: accept when req_valid && req_ready. Request fields are sampled in the accept cycle. There is no back-pressure on responses.
- A new request may be accepted in the same cycle resp_valid is high.
- Byte lanes are little-endian.
  - o = addr[1:0]; size n = 1/2/4 bytes.
  - Split when o+n > 4.
  - Word A = addr[WORD_ADDR_W+1:2]; word B = A+1.
  - Word A uses lanes o..3. Word B uses lanes 0..(o+n-5).
- Error checks at accept:
  - Error when req_width == 2'b11, or addr[31:WORD_ADDR_W+2] != 0, or the last byte (addr+n-1) exceeds the top of the byte space. There is no wrap to word 0.
  - On error: no SRAM activity; resp_valid=1 and resp_err=1 at T+1; resp_rdata=0.
- SRAM drive is combinational in the accept cycle T. The sram_* outputs are held at 0 whenever no access is being issued.
- FSM states: IDLE, RD_A, RD_B, WR_B.
  - Aligned read: issue A at T, go to RD_A. In RD_A capture lanes, register the response, return to IDLE; resp_valid at T+2.
  - Split read: issue A at T. In RD_A (T+1) capture A's lanes and issue B, go to RD_B. In RD_B capture, assemble, return to IDLE; resp_valid at T+3.
  - Aligned write: write at T with the computed sram_we; resp_valid at T+1.
  - Split write: write A at T, go to WR_B. Write B at T+1, return to IDLE; resp_valid at T+2.
- Load assembly: concatenate the n bytes in address order (lowest address = LSB).
  - If req_signed and n < 4, replicate the top bit of the assembled value.
  - Otherwise zero-extend.
- Store: byte k of req_wdata (k < n) goes to address addr+k.

Decomposition:
- Package mem_pkg holds:
  - MEM_WIDTH_B = 2'b00, MEM_WIDTH_H = 2'b01, MEM_WIDTH_W = 2'b10
  - MEM_READ = 1'b1, MEM_WRITE = 1'b0
  - FSM state encoding
- One sub-module, lane_align: combinational function of (offset, width, wdata, rdata_A, rdata_B). It outputs the A/B byte enables, the lane-shifted write data for A and B, and the extended load value. It is shared by the read and write paths.

Test Plan:
- Aligned LW: SRAM word 0x10 = 0xDEADBEEF; read addr 0x40, width W -> sram_en at T with sram_addr=0x10, resp_valid at T+2, resp_rdata=0xDEADBEEF, resp_err=0.
- LB signed vs LBU: word 0 = 0x00800000; read addr 0x2, width B, signed=1 -> 0xFFFFFF80; signed=0 -> 0x00000080.
- Split LW: words 0 and 1 = 0x44332211 and 0x88776655; read addr 0x3, width W -> two SRAM reads (words 0 and 1), resp_valid at T+3, rdata=0x77665544.
- Split SH: addr 0x7, wdata 0x0000BEEF -> T: addr 1, we=4'b1000, wdata[31:24]=0xEF. T+1: addr 2, we=4'b0001, wdata[7:0]=0xBE. resp_valid at T+2.
- Errors:
  - Width 2'b11 -> resp_err=1 at T+1, no sram_en.
  - Addr 0x0001_0000 with WORD_ADDR_W=14 -> resp_err=1 at T+1, no sram_en.
  - LW at 0xFFFE -> resp_err=1 at T+1, no sram_en.
- Reset mid-split-read: assert rst in RD_A -> outputs 0 the same cycle, no resp_valid. After release, an aligned read completes normally at T+2.
